// File: rtl/dice_roll_ctrl.sv
// N-die roller: debounced roll button, LFSR seeded from a free-running counter on the first press,
// timed shuffle animation with per-die hold, then a one-cycle done pulse with the registered dice sum.
module dice_roll_ctrl #(
    parameter int N_DICE          = 4,
    parameter int SIDES           = 6,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ROLL_CYCLES     = 50_000_000,
    parameter int SHUFFLE_DIV     = 5_000_000,
    localparam int SUM_W          = $clog2(N_DICE*SIDES+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_roll,
    input  logic [N_DICE-1:0]     hold,
    output logic [4*N_DICE-1:0]   dice_vals,
    output logic [SUM_W-1:0]      sum,
    output logic                  rolling,
    output logic                  done,
    output logic                  seeded
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RC_W = $clog2(ROLL_CYCLES + 1);
    localparam int SD_W = $clog2(SHUFFLE_DIV + 1);
    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        SETTLE
    } state_e;

    state_e state_q, state_d;

    logic                sync1_q, sync2_q;
    logic                db_q, db_d, dbPrev_q;
    logic [DB_W-1:0]     dbCnt_q, dbCnt_d;
    logic                press;

    logic [15:0]         freeCnt_q, freeCnt_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [15:0]         lfsrStep, seedVal;
    logic                seeded_q, seeded_d;

    logic [RC_W-1:0]     rollCnt_q, rollCnt_d;
    logic [SD_W-1:0]     shufCnt_q, shufCnt_d;
    logic                lastRoll, shufTick;

    logic [4*N_DICE-1:0] dice_q, dice_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [SUM_W-1:0]    diceSum;
    logic                done_q, done_d;
    logic [3:0]          face [N_DICE];

    // Face for die idx: low byte of the LFSR rotated left by 3*idx, folded into 1..SIDES.
    function automatic logic [3:0] faceOf(input logic [15:0] l, input int idx);
        logic [31:0] dbl;
        logic [7:0]  s;
        logic [7:0]  m;
        dbl = {l, l} << (3 * idx);
        s   = dbl[23:16];
        m   = s % 8'(SIDES);
        return 4'(m + 8'd1);
    endfunction

    // The raw button is asynchronous, so it passes through two flops before the debouncer sees it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            dbPrev_q <= 1'b0;
            dbCnt_q  <= '0;
        end else begin
            sync1_q  <= btn_roll;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            dbPrev_q <= db_q;
            dbCnt_q  <= dbCnt_d;
        end
    end

    always_comb begin
        db_d    = db_q;
        dbCnt_d = '0;
        if (sync2_q != db_q) begin
            if (dbCnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = ~db_q;
            end else begin
                dbCnt_d = dbCnt_q + DB_W'(1);
            end
        end
    end

    assign press = db_q & ~dbPrev_q;

    // A zero seed would lock the LFSR, so that one case falls back to the reset pattern.
    always_comb begin
        lfsrStep  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        seedVal   = freeCnt_q ^ LFSR_INIT;
        if (seedVal == 16'h0000) begin
            seedVal = LFSR_INIT;
        end
        freeCnt_d = freeCnt_q + 16'd1;
        seeded_d  = seeded_q;
        lfsr_d    = lfsrStep;
        if (press && !seeded_q) begin
            lfsr_d   = seedVal;
            seeded_d = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_DICE; i++) begin
            face[i] = faceOf(lfsr_q, i);
        end
    end

    always_comb begin
        diceSum = '0;
        for (int i = 0; i < N_DICE; i++) begin
            diceSum = diceSum + SUM_W'(dice_q[4*i +: 4]);
        end
    end

    assign lastRoll = (rollCnt_q == RC_W'(ROLL_CYCLES - 1));
    assign shufTick = (shufCnt_q == SD_W'(SHUFFLE_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A press landing on the done cycle is dropped so back-to-back rolls always show done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press && !done_q) state_d = ROLL;
            ROLL:    if (lastRoll)         state_d = SETTLE;
            SETTLE:                        state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_comb begin
        rolling = (state_q == ROLL);
    end

    always_comb begin
        rollCnt_d = rollCnt_q;
        shufCnt_d = shufCnt_q;
        dice_d    = dice_q;
        sum_d     = sum_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (state_d == ROLL) begin
                    rollCnt_d = '0;
                    shufCnt_d = '0;
                end
            end
            ROLL: begin
                rollCnt_d = rollCnt_q + RC_W'(1);
                shufCnt_d = shufTick ? '0 : shufCnt_q + SD_W'(1);
                if (shufTick) begin
                    for (int i = 0; i < N_DICE; i++) begin
                        if (!hold[i]) begin
                            dice_d[4*i +: 4] = face[i];
                        end
                    end
                end
            end
            SETTLE: begin
                sum_d  = diceSum;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freeCnt_q <= '0;
            lfsr_q    <= LFSR_INIT;
            seeded_q  <= 1'b0;
            rollCnt_q <= '0;
            shufCnt_q <= '0;
            dice_q    <= '0;
            sum_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            freeCnt_q <= freeCnt_d;
            lfsr_q    <= lfsr_d;
            seeded_q  <= seeded_d;
            rollCnt_q <= rollCnt_d;
            shufCnt_q <= shufCnt_d;
            dice_q    <= dice_d;
            sum_q     <= sum_d;
            done_q    <= done_d;
        end
    end

    assign dice_vals = dice_q;
    assign sum       = sum_q;
    assign done      = done_q;
    assign seeded    = seeded_q;

endmodule
